// File: rtl/alu_pkg.sv
// alu_pkg: shared types and decode for the alu_mdu execute unit.
//   - alu_op_e  : internal ALU/MDU operation selector
//   - state_e   : alu_mdu handshake FSM states
//   - OPC_* / F3_* / F7_* : RV opcode, funct3 and funct7 encodings
//   - decode_op : pure (opcode, funct3, funct7) -> alu_op_e mapping
// Optional feature macro: ALU_MDU_MULDIV_EN enables RV32M decode.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_COPY_A, ALU_COPY_B,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_XXX
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Shared OP/OP-IMM integer decode; sra_sel picks SRA over SRL.
  function automatic alu_op_e base_op(input logic [2:0] funct3, input logic sra_sel);
    case (funct3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return sra_sel ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

`ifdef ALU_MDU_MULDIV_EN
  function automatic alu_op_e muldiv_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction
`endif

  function automatic alu_op_e decode_op(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    alu_op_e op;
    op = ALU_XXX;
    case (opcode)
      OPC_OP_IMM: op = base_op(funct3, funct7[5]);
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          op = base_op(funct3, 1'b0);
        end else if (funct7 == F7_ALT) begin
          // Only SUB and SRA have an alternate form under OP.
          if (funct3 == F3_ADD)     op = ALU_SUB;
          else if (funct3 == F3_SR) op = ALU_SRA;
          else                      op = ALU_XXX;
        end
`ifdef ALU_MDU_MULDIV_EN
        else if (funct7 == F7_MULDIV) begin
          op = muldiv_op(funct3);
        end
`endif
        else begin
          op = ALU_XXX;
        end
      end
      OPC_LUI: op = ALU_COPY_B;
      OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE: op = ALU_ADD;
      OPC_SYSTEM: begin
        if (funct3 == F3_CSRRW)       op = ALU_COPY_A;
        else if (funct3 == F3_CSRRWI) op = ALU_COPY_B;
        else                          op = ALU_XXX;
      end
      default: op = ALU_XXX;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: serial restoring divider on unsigned magnitudes, one quotient
// bit per cycle. start loads the operands; XLEN cycles later done pulses
// for one cycle, during which quotient/remainder carry the final values
// (they are the combinational result of the last step, so the caller
// captures them on the same edge).
// Ports: clk, rst_n, abort (drop the op in flight), start, dividend,
//        divisor, done, quotient, remainder.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] rem_step, quo_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor and keep the difference if it is
  // non-negative. The extra top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_q};
    if (diff[XLEN+1]) begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // NOTE: every always_comb assigns each output a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CW'(XLEN);
    end else if (cnt_q != '0) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute unit. Decodes opcode/funct3/funct7, computes
// the ALU (and optionally RV32M) result and returns it registered.
// Ports: clk, rst_n (async active-low), flush (sync abandon),
//        in_valid/in_ready (request), opcode, funct3, funct7, op_a, op_b,
//        out_valid/out_ready (response), result, illegal.
// Macro ALU_MDU_MULDIV_EN builds multiply, divide and the DIV state;
// without it funct7=0000001 under OP decodes as illegal.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  alu_op_e         op;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            start_div;
  logic            accept;

  assign op       = decode_op(opcode, funct3, funct7);
  assign shamt    = op_b[SHW-1:0];
  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MDU_MULDIV_EN
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic              a_signed, b_signed;
  logic              div_signed, div_is_rem, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, div_quo, div_rem, div_raw, div_fix;
  logic              div_done;
  logic              neg_q, neg_d, is_rem_q, is_rem_d;

  // Extending both operands to 2*XLEN makes one unsigned multiply give the
  // correct low 2*XLEN bits for every signedness combination.
  assign a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign b_signed = (op == ALU_MULH);
  assign a_ext    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
  assign b_ext    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
  assign prod     = a_ext * b_ext;

  assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
  assign div_is_rem = (op == ALU_REM) || (op == ALU_REMU);
  assign a_neg      = div_signed & op_a[XLEN-1];
  assign b_neg      = div_signed & op_b[XLEN-1];
  assign a_mag      = a_neg ? -op_a : op_a;
  assign b_mag      = b_neg ? -op_b : op_b;

  // Remainder follows the dividend sign; quotient is negative when signs differ.
  assign is_rem_d = accept ? div_is_rem : is_rem_q;
  assign neg_d    = accept ? (div_is_rem ? a_neg : (a_neg ^ b_neg)) : neg_q;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .start     (accept && start_div && !flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_raw = is_rem_q ? div_rem : div_quo;
  assign div_fix = neg_q ? -div_raw : div_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      neg_q    <= neg_d;
      is_rem_q <= is_rem_d;
    end
  end
`endif

  always_comb begin
    alu_res   = '0;
    start_div = 1'b0;
    case (op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_COPY_A: alu_res = op_a;
      ALU_COPY_B: alu_res = op_b;
`ifdef ALU_MDU_MULDIV_EN
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        // Divide-by-zero and signed overflow resolve without the divider.
        if (op_b == '0) begin
          alu_res = div_is_rem ? op_a : '1;
        end else if (div_signed && op_a == MIN_INT && op_b == '1) begin
          alu_res = div_is_rem ? '0 : MIN_INT;
        end else begin
          start_div = 1'b1;
        end
      end
`endif
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            result_d  = alu_res;
            illegal_d = (op == ALU_XXX);
            state_d   = start_div ? S_DIV : S_DONE;
          end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
          end
        end
`ifdef ALU_MDU_MULDIV_EN
        S_DIV: begin
          if (div_done) begin
            result_d = div_fix;
            state_d  = S_DONE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (XLEN=32).
// Expectations for RV32M ops depend on ALU_MDU_MULDIV_EN as built.
`timescale 1ns/1ps
module tb_alu_mdu;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] SYS    = 7'b1110011;
  localparam logic [6:0] BAD    = 7'h7F;
  localparam logic [6:0] F7_B   = 7'b0000000;
  localparam logic [6:0] F7_A   = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one request; it is accepted on the next rising edge. Returns
  // #1 after that edge with in_valid dropped.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = opc; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single-cycle op: result must be visible right after the accept edge.
  task automatic one(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_ill);
    issue(opc, f3, f7, a, b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ill"}, 32'(illegal), 32'(exp_ill));
  endtask

  // Multi-cycle divide: count edges from acceptance (accept edge = 1),
  // bounded, watching in_ready stays low throughout.
  task automatic long_div(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
    int n;
    int ready_hi;
    ready_hi = 0;
    issue(OP, f3, F7_M, a, b);
    n = 1;
    while (!out_valid && n < 100) begin
      if (in_ready) ready_hi++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd33);
    check({tag, "_rdy_lo"}, 32'(ready_hi), 32'd0);
    check({tag, "_res"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops, out_ready held high
    one("add",  OP, 3'b000, F7_B, 32'd5, 32'd7, 32'd12, 1'b0);
    one("sub",  OP, 3'b000, F7_A, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    one("srai", OP_IMM, 3'b101, F7_A, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    one("srli", OP_IMM, 3'b101, F7_B, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    one("slt",  OP, 3'b010, F7_B, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    one("sltu", OP, 3'b011, F7_B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    one("sll",  OP, 3'b001, F7_B, 32'd3, 32'h0000_0021, 32'd6, 1'b0);
    one("lui",  LUI, 3'b000, F7_B, 32'h1111_1111, 32'h1234_5000, 32'h1234_5000, 1'b0);
    one("csrrw", SYS, 3'b001, F7_B, 32'hCAFE_0001, 32'd9, 32'hCAFE_0001, 1'b0);
    one("bad_opc", BAD, 3'b000, F7_B, 32'd5, 32'd7, 32'd0, 1'b1);
    one("bad_f7", OP, 3'b001, F7_A, 32'd5, 32'd7, 32'd0, 1'b1);
    @(posedge clk); #1;
    check("idle_after_done", 32'(out_valid), 32'd0);

`ifdef ALU_MDU_MULDIV_EN
    one("mul",    OP, 3'b000, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    one("mulh",   OP, 3'b001, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    one("mulhsu", OP, 3'b010, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    one("mulhu",  OP, 3'b011, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    one("divu0",  OP, 3'b101, F7_M, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
    one("remu0",  OP, 3'b111, F7_M, 32'h1234, 32'd0, 32'h1234, 1'b0);
    one("div_ovf", OP, 3'b100, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    one("rem_ovf", OP, 3'b110, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    long_div("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    long_div("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    long_div("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    long_div("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
    long_div("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
    long_div("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);
    check("div_ill", 32'(illegal), 32'd0);
    @(posedge clk); #1;

    // Reset asserted during cycle 10 of a divide takes effect at once
    issue(OP, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // flush mid-divide: IDLE on next edge, no out_valid pulse afterwards
    issue(OP, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    check("flush_no_pulse", 32'(pulses), 32'd0);
`else
    one("mul_off", OP, 3'b000, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    one("div_off", OP, 3'b100, F7_M, 32'd7, 32'd2, 32'd0, 1'b1);
    @(posedge clk); #1;
`endif

    // flush beats a simultaneous accept
    flush = 1'b1;
    issue(OP, 3'b000, F7_B, 32'd1, 32'd1);
    flush = 1'b0;
    check("flush_vs_accept", 32'(out_valid), 32'd0);

    // Backpressure: result held for 3 cycles, then accept-on-release
    out_ready = 1'b0;
    issue(OP, 3'b000, F7_B, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_res", result, 32'd3);
      check("bp_ready_lo", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_hi", 32'(in_ready), 32'd1);
    one("bp_next", OP, 3'b100, F7_B, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
